// File: rtl/lsu_if.sv
// lsu_if: bundles the core-side request/response signals and the word-wide
// data-memory port of the load/store unit. The slave view belongs to the
// lsu itself; the master view belongs to whatever drives it (core + memory).
interface lsu_if;
    // core side
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic        misaligned;
    logic [31:0] load_data;
    // memory side
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output stall, done, misaligned, load_data,
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  stall, done, misaligned, load_data,
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
endinterface

// File: rtl/lsu.sv
// lsu: RV32I load/store unit. Captures a load/store from the core, checks
// legality and alignment, issues one word access on the grant/response
// memory port, and returns the extended load result with a done pulse.
module lsu (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

    state_t      state_reg;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] addr_reg;
    logic        mem_req_reg;
    logic        mem_we_reg;
    logic [3:0]  mem_wstrb_reg;
    logic [31:0] mem_wdata_reg;
    logic        done_reg;
    logic        err_reg;
    logic [31:0] load_data_reg;

    logic        req_illegal;
    logic        req_misal;
    logic [3:0]  steer_strb;
    logic [31:0] steer_wdata;
    logic [31:0] rdata_shifted;
    logic [31:0] load_ext;

    // Decode the incoming request: legality, alignment and store lane steering.
    always_comb begin
        if (bus.req_we)
            req_illegal = (bus.req_funct3 > 3'b010);
        else
            req_illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);

        req_misal = 1'b0;
        if (bus.req_funct3[1:0] == 2'b01)
            req_misal = bus.req_addr[0];
        else if (bus.req_funct3[1:0] == 2'b10)
            req_misal = (bus.req_addr[1:0] != 2'b00);

        steer_strb  = 4'b0000;
        steer_wdata = 32'h0000_0000;
        if (bus.req_we) begin
            case (bus.req_funct3[1:0])
                2'b00: begin
                    steer_strb  = 4'b0001 << bus.req_addr[1:0];
                    steer_wdata = {4{bus.req_wdata[7:0]}};
                end
                2'b01: begin
                    steer_strb  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                    steer_wdata = {2{bus.req_wdata[15:0]}};
                end
                default: begin
                    steer_strb  = 4'b1111;
                    steer_wdata = bus.req_wdata;
                end
            endcase
        end
    end

    // Align the returned word to the addressed byte and extend it.
    always_comb begin
        rdata_shifted = bus.mem_rdata >> {addr_reg[1:0], 3'b000};
        case (funct3_reg)
            3'b000:  load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            3'b100:  load_ext = {24'h000000, rdata_shifted[7:0]};
            3'b101:  load_ext = {16'h0000, rdata_shifted[15:0]};
            default: load_ext = rdata_shifted;
        endcase
    end

    // Access sequencer: capture in IDLE, hold the request until granted,
    // wait for read data, then a single FIN cycle that completes the access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            funct3_reg    <= 3'b000;
            addr_reg      <= 32'h0000_0000;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_wstrb_reg <= 4'b0000;
            mem_wdata_reg <= 32'h0000_0000;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            load_data_reg <= 32'h0000_0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_reg     <= bus.req_we;
                        funct3_reg <= bus.req_funct3;
                        addr_reg   <= bus.req_addr;
                        if (req_illegal || req_misal) begin
                            // faulting accesses never touch memory
                            err_reg   <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= FIN;
                        end else begin
                            mem_req_reg   <= 1'b1;
                            mem_we_reg    <= bus.req_we;
                            mem_wstrb_reg <= steer_strb;
                            mem_wdata_reg <= steer_wdata;
                            state_reg     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        mem_req_reg   <= 1'b0;
                        mem_we_reg    <= 1'b0;
                        mem_wstrb_reg <= 4'b0000;
                        mem_wdata_reg <= 32'h0000_0000;
                        if (we_reg) begin
                            done_reg  <= 1'b1;
                            state_reg <= FIN;
                        end else if (bus.mem_rvalid) begin
                            load_data_reg <= load_ext;
                            done_reg      <= 1'b1;
                            state_reg     <= FIN;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        load_data_reg <= load_ext;
                        done_reg      <= 1'b1;
                        state_reg     <= FIN;
                    end
                end
                FIN: begin
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The core is released in FIN; a dropped req_valid never stalls it.
    assign bus.stall      = bus.req_valid && (state_reg != FIN);
    assign bus.done       = done_reg;
    assign bus.misaligned = err_reg;
    assign bus.load_data  = load_data_reg;
    assign bus.mem_req    = mem_req_reg;
    assign bus.mem_we     = mem_we_reg;
    assign bus.mem_addr   = {addr_reg[31:2], 2'b00};
    assign bus.mem_wstrb  = mem_wstrb_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the single-cycle RISC-V core. It sits directly downstream of the ALU: the ALU result is the effective address for loads and stores. The unit turns a load or store into a request on a word-wide data-memory port with a grant/response handshake, and holds the core with `stall` until the access completes. It handles byte-lane steering, store strobes, load sign/zero extension and misalignment detection.

## Interface
- No parameters. The address and data paths are fixed at 32 bits (RV32I).
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: the current instruction is a load or store. The core holds it and all other `req_*` inputs until `done`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: the instruction's funct3 field.
- `req_addr` in 32: effective address, taken from the ALU result.
- `req_wdata` in 32: store data (rs2).
- `stall` out 1: freezes the PC and register-file write.
- `done` out 1: one-cycle completion pulse.
- `misaligned` out 1: one-cycle pulse, coincident with `done`; the access was misaligned or illegal.
- `load_data` out 32: the extended load result.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: word-aligned memory address.
- `mem_wstrb` out 4: byte-lane write strobes.
- `mem_wdata` out 32: lane-replicated write data.
- `mem_gnt` in 1: memory has accepted the request.
- `mem_rvalid` in 1: read data is valid.
- `mem_rdata` in 32: read data.

## Operation
- FSM states are IDLE, REQ, WAIT and FIN.
- **IDLE**: when `req_valid` = 1, register we, funct3, addr, the steered write data and the strobes.
  - Illegal or misaligned access: set the error flag and go to FIN.
  - Otherwise go to REQ.
  - Illegal funct3: loads 011, 110 and 111; stores any value > 010.
  - Misaligned: halfword with addr[0] = 1; word with addr[1:0] ≠ 0.
- **REQ**: drive `mem_req` = 1, with the memory outputs taken from the registered request. Hold them until `mem_gnt` = 1.
  - Store granted: go to FIN.
  - Load granted with `mem_rvalid` = 1 in the same cycle: capture the data and go to FIN.
  - Load granted without `mem_rvalid`: go to WAIT.
- **WAIT**: on `mem_rvalid` = 1, capture the data and go to FIN.
- **FIN**: `done` = 1, `misaligned` = error flag, then go to IDLE. Clear the error flag.
- `stall` = `req_valid` AND (state ≠ FIN). The core advances on the edge that ends FIN.
- Memory outputs:
  - `mem_addr` = {addr[31:2], 2'b00}.
  - `mem_we`, `mem_wstrb` and `mem_wdata` are driven only while `mem_req` = 1, and are 0 otherwise.
  - `mem_wstrb` = 0 for loads.
- Store steering:
  - SB: strb = 1 << addr[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: strb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{rs2[15:0]}}.
  - SW: strb = 4'b1111; wdata = rs2.
- Load extraction: shift `mem_rdata` right by 8·addr[1:0], then extend to 32 bits.
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- `load_data` is registered and holds its value until the next successful load. Stores and faulting accesses leave it unchanged.
- Misaligned or illegal accesses never raise `mem_req`.
- Changes on `req_*` after the IDLE capture are ignored.
- If `req_valid` drops mid-transaction, the transaction still completes. `done` pulses and `stall` is 0.
- `mem_rvalid` is ignored in IDLE and FIN, and in REQ for stores.

## Timing
- Reset values: state IDLE, all outputs 0 (`mem_req`, `done`, `misaligned`, `load_data`, strobes, data), error flag 0.
- Reset asserted mid-transaction: the access is aborted and `mem_req` drops immediately (asynchronously). A late `mem_rvalid` after reset release is ignored.
- Memory outputs are registered. `mem_req` rises one cycle after `req_valid` is first seen in IDLE.
- Best-case latency, counting cycle 0 as the first `req_valid` cycle:
  - Store: REQ with gnt in cycle 1, FIN in cycle 2. `stall` is high for cycles 0–1.
  - Load: gnt in cycle 1, rvalid in cycle 2, FIN in cycle 3.
  - Load with gnt and rvalid together in cycle 1: FIN in cycle 2.
- Fault: FIN in cycle 1 with `misaligned` = `done` = 1.
- `load_data` is valid in the FIN cycle and afterwards.
- Exactly one `done` pulse per accepted request.
- Back-to-back accesses: the next request is sampled in the IDLE cycle that follows FIN, so there is at least one idle cycle between requests.

## Test plan
- **LW, minimum latency**: LW at 0x100, gnt in cycle 1, rvalid in cycle 2 with rdata 0xDEADBEEF.
  - `mem_addr` = 0x100 and `mem_wstrb` = 0.
  - `load_data` = 0xDEADBEEF with `done` in cycle 3.
  - `stall` high in cycles 0–2, low in cycle 3.
- **Load extension**, rdata 0x80FF1234:
  - LB at 0x103 → 0xFFFFFF80.
  - LBU at 0x103 → 0x00000080.
  - LH at 0x102 → 0xFFFF80FF.
  - LHU at 0x102 → 0x000080FF.
  - LB at 0x100 → 0x00000034.
- **Store steering**:
  - SB at 0x201 with rs2 0x000000AB → `mem_addr` 0x200, `mem_wstrb` 0010, `mem_wdata` 0xABABABAB, `mem_we` 1, `done` in cycle 2.
  - SH at 0x202 with rs2 0x12345678 → `mem_wstrb` 1100, `mem_wdata` 0x56785678.
- **Faults**: LW at 0x102, SH at 0x301 and load funct3 011.
  - `mem_req` never rises.
  - `misaligned` = `done` = 1 in cycle 1.
  - `load_data` unchanged.
- **Handshake stretch**: gnt delayed 3 cycles, then rvalid 2 cycles after gnt.
  - `mem_req` and `mem_addr` stable until gnt.
  - `req_addr` changed mid-wait has no effect.
  - A single `done` pulse; `stall` high throughout until FIN.
- **Reset in WAIT**: assert `rst` during WAIT.
  - All outputs 0 in the same cycle.
  - A post-reset rvalid is ignored.
  - A following LW at 0x0 completes normally.
